// File: rtl/burst_piso_serializer_pkg.sv
// Shared constants for the burst PISO serializer: word-select codes, FSM states, FIFO entry layout.
package piso_pkg;

   localparam logic [1:0] WSEL_FULL = 2'b11;
   localparam logic [1:0] WSEL_LO   = 2'b01;
   localparam logic [1:0] WSEL_HI   = 2'b10;
   localparam logic [1:0] WSEL_BAD  = 2'b00;

   // FIFO entry = {word_sel, msb_first, data}
   localparam int ENTRY_TAG_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_SHIFT  = 2'b10,
      ST_PARITY = 2'b11
   } piso_state_e;

   function automatic int entry_width(input int bus_width);
      return bus_width + ENTRY_TAG_W;
   endfunction

endpackage

// File: rtl/burst_piso_serializer_if.sv
// Handshake and serial-link bundle of the burst PISO serializer; slave side is the serializer.
interface burst_piso_serializer_if #(
   parameter int BUS_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
);
   logic                          en;
   logic                          in_valid;
   logic                          in_ready;
   logic [BUS_WIDTH-1:0]          data_in;
   logic [1:0]                    word_sel;
   logic                          msb_first;
   logic                          ser_out;
   logic                          ser_valid;
   logic                          word_done;
   logic                          burst_done;
   logic                          sel_err;
   logic                          busy;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport slave (
      input  en, in_valid, data_in, word_sel, msb_first,
      output in_ready, ser_out, ser_valid, word_done, burst_done, sel_err, busy, fifo_count
   );

   modport master (
      output en, in_valid, data_in, word_sel, msb_first,
      input  in_ready, ser_out, ser_valid, word_done, burst_done, sel_err, busy, fifo_count
   );
endinterface

// File: rtl/burst_piso_serializer_fifo.sv
// piso_fifo: synchronous FIFO holding serializer entries; head word is visible combinationally on rdata.
module piso_fifo
   import piso_pkg::*;
#(
   parameter int WIDTH = 16 + ENTRY_TAG_W,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rdata,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == (AW+1)'(0));

endmodule

// File: rtl/burst_piso_serializer.sv
// Buffered parallel-in/serial-out converter for MRAM read bursts (FIFO + FSM + shifter).
// Define PISO_PARITY_EN to append an even-parity bit after every word.
module burst_piso_serializer
   import piso_pkg::*;
#(
   parameter int BUS_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   burst_piso_serializer_if.slave  bus
);
   localparam int CNT_W   = $clog2(BUS_WIDTH + 1);
   localparam int HALF    = BUS_WIDTH / 2;
   localparam int ENTRY_W = entry_width(BUS_WIDTH);

   piso_state_e              state_r, state_nx_s;
   logic [ENTRY_W-1:0]       fifo_rdata_s;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
   logic                     fifo_full_s, fifo_empty_s;
   logic                     push_s, pop_s, last_bit_s, frame_end_s;
   logic [BUS_WIDTH-1:0]     data_r, sh_r;
   logic [1:0]               sel_r;
   logic                     msbf_r;
   logic [CNT_W-1:0]         cnt_r;
   logic                     ser_out_r, ser_valid_r, word_done_r, burst_done_r, sel_err_r;
`ifdef PISO_PARITY_EN
   logic                     par_r;

   function automatic logic sel_parity(input logic [BUS_WIDTH-1:0] d, input logic [1:0] sel);
      case (sel)
         WSEL_FULL: sel_parity = ^d;
         WSEL_LO:   sel_parity = ^d[HALF-1:0];
         WSEL_HI:   sel_parity = ^d[BUS_WIDTH-1:HALF];
         default:   sel_parity = 1'b0;
      endcase
   endfunction
`endif

   // Move the selected half to the end the shifter reads from, so both orders shift uniformly.
   function automatic logic [BUS_WIDTH-1:0] align_word(input logic [BUS_WIDTH-1:0] d,
                                                     input logic [1:0] sel, input logic msbf);
      case (sel)
         WSEL_LO: align_word = msbf ? (d << HALF) : d;
         WSEL_HI: align_word = msbf ? d : (d >> HALF);
         default: align_word = d;
      endcase
   endfunction

   assign push_s     = bus.in_valid && !fifo_full_s;
   assign last_bit_s = (state_r == ST_SHIFT) && bus.en && (cnt_r == CNT_W'(1));
`ifdef PISO_PARITY_EN
   assign frame_end_s = (state_r == ST_PARITY) && bus.en;
`else
   assign frame_end_s = last_bit_s;
`endif

   piso_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata ({bus.word_sel, bus.msb_first, bus.data_in}),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and pop decision; a finishing frame chains straight into the next entry.
   always_comb begin
      state_nx_s = state_r;
      pop_s      = frame_end_s && !fifo_empty_s;
      case (state_r)
         ST_IDLE: begin
            pop_s      = !fifo_empty_s;
            state_nx_s = fifo_empty_s ? ST_IDLE : ST_LOAD;
         end
         ST_LOAD: begin
            state_nx_s = (sel_r == WSEL_BAD) ? ST_IDLE : ST_SHIFT;
         end
`ifdef PISO_PARITY_EN
         ST_SHIFT: begin
            state_nx_s = last_bit_s ? ST_PARITY : ST_SHIFT;
         end
         ST_PARITY: begin
            if (frame_end_s) begin
               state_nx_s = fifo_empty_s ? ST_IDLE : ST_LOAD;
            end else begin
               state_nx_s = ST_PARITY;
            end
         end
`else
         ST_SHIFT: begin
            if (frame_end_s) begin
               state_nx_s = fifo_empty_s ? ST_IDLE : ST_LOAD;
            end else begin
               state_nx_s = ST_SHIFT;
            end
         end
`endif
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Entry latch, shifter, bit counter and registered link outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r       <= '0;
         sel_r        <= 2'b00;
         msbf_r       <= 1'b0;
         sh_r         <= '0;
         cnt_r        <= '0;
         ser_out_r    <= 1'b0;
         ser_valid_r  <= 1'b0;
         word_done_r  <= 1'b0;
         burst_done_r <= 1'b0;
         sel_err_r    <= 1'b0;
`ifdef PISO_PARITY_EN
         par_r        <= 1'b0;
`endif
      end else begin
         sel_err_r    <= (state_r == ST_LOAD) && (sel_r == WSEL_BAD);
         word_done_r  <= frame_end_s;
         burst_done_r <= frame_end_s && fifo_empty_s;
         ser_valid_r  <= ((state_r == ST_SHIFT) || (state_r == ST_PARITY)) && bus.en;
         if (pop_s) begin
            {sel_r, msbf_r, data_r} <= fifo_rdata_s;
         end
         case (state_r)
            ST_IDLE: begin
               ser_out_r <= 1'b0;
            end
            ST_LOAD: begin
               sh_r  <= align_word(data_r, sel_r, msbf_r);
               cnt_r <= (sel_r == WSEL_FULL) ? CNT_W'(BUS_WIDTH) : CNT_W'(HALF);
`ifdef PISO_PARITY_EN
               par_r <= sel_parity(data_r, sel_r);
`endif
            end
            ST_SHIFT: begin
               if (bus.en) begin
                  ser_out_r <= msbf_r ? sh_r[BUS_WIDTH-1] : sh_r[0];
                  sh_r      <= msbf_r ? {sh_r[BUS_WIDTH-2:0], 1'b0} : {1'b0, sh_r[BUS_WIDTH-1:1]};
                  cnt_r     <= cnt_r - CNT_W'(1);
               end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
               if (bus.en) begin
                  ser_out_r <= par_r;
               end
            end
`endif
            default: begin
               ser_out_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = !fifo_full_s;
   assign bus.fifo_count = fifo_count_s;
   assign bus.busy       = (state_r != ST_IDLE) || !fifo_empty_s;
   assign bus.ser_out    = ser_out_r;
   assign bus.ser_valid  = ser_valid_r;
   assign bus.word_done  = word_done_r;
   assign bus.burst_done = burst_done_r;
   assign bus.sel_err    = sel_err_r;

endmodule
